// File: rtl/vga_timing_gen_if.sv
// Video bus between the VGA timing generator, its pixel source and the DAC.
// Palette write signals exist only when VGA_PALETTE_EN is defined.
interface vga_timing_gen_if #(
  parameter int unsigned COORD_W = 11
);
  logic               CE;
  logic [7:0]         color;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_valid;
  logic               line_start;
  logic               frame_start;
  logic [7:0]         R;
  logic [7:0]         G;
  logic [7:0]         B;
  logic               HS;
  logic               VS;
  logic               BLANK;
  logic               VGA_SYNC;
  logic               VGA_CLK;
`ifdef VGA_PALETTE_EN
  logic               pal_we;
  logic [3:0]         pal_addr;
  logic [23:0]        pal_data;

  modport master (
    input  CE, color, pal_we, pal_addr, pal_data,
    output pix_x, pix_y, pix_valid, line_start, frame_start,
    output R, G, B, HS, VS, BLANK, VGA_SYNC, VGA_CLK
  );
  modport slave (
    output CE, color, pal_we, pal_addr, pal_data,
    input  pix_x, pix_y, pix_valid, line_start, frame_start,
    input  R, G, B, HS, VS, BLANK, VGA_SYNC, VGA_CLK
  );
`else
  modport master (
    input  CE, color,
    output pix_x, pix_y, pix_valid, line_start, frame_start,
    output R, G, B, HS, VS, BLANK, VGA_SYNC, VGA_CLK
  );
  modport slave (
    output CE, color,
    input  pix_x, pix_y, pix_valid, line_start, frame_start,
    input  R, G, B, HS, VS, BLANK, VGA_SYNC, VGA_CLK
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with latency-matched sync/blank/colour output stage.
// Define VGA_PALETTE_EN for a 16-entry writable palette instead of RGB332 decode.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned PIX_LAT    = 1,
  parameter int unsigned COORD_W    = 11
) (
  input  logic             CLK,
  input  logic             RST,
  vga_timing_gen_if.master bus
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] HAct     = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] HSyncBeg = COORD_W'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_W-1:0] HSyncEnd = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] HLast    = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] VAct     = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] VSyncBeg = COORD_W'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_W-1:0] VSyncEnd = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [COORD_W-1:0] VLast    = COORD_W'(V_TOTAL - 1);

  logic [COORD_W-1:0] r_h;
  logic [COORD_W-1:0] r_v;
  logic               w_hs0, w_vs0, w_blank0;
  logic               w_hs_d, w_vs_d, w_blank_d;
  logic [23:0]        w_rgb;
  logic [7:0]         r_r, r_g, r_b;
  logic               r_hs, r_vs, r_blank;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_h <= '0;
      r_v <= '0;
    end else if (bus.CE) begin
      if (r_h == HLast) begin
        r_h <= '0;
        r_v <= (r_v == VLast) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign w_blank0 = (r_h < HAct) && (r_v < VAct);
  assign w_hs0    = (r_h >= HSyncBeg) && (r_h < HSyncEnd);
  assign w_vs0    = (r_v >= VSyncBeg) && (r_v < VSyncEnd);

  assign bus.pix_x       = r_h;
  assign bus.pix_y       = r_v;
  assign bus.pix_valid   = w_blank0;
  assign bus.line_start  = (r_h == '0);
  assign bus.frame_start = (r_h == '0) && (r_v == '0);

  // Delay line matches the source's colour latency so sync/blank stay aligned with RGB.
  generate
    if (PIX_LAT == 0) begin : g_no_dl
      assign w_hs_d    = w_hs0;
      assign w_vs_d    = w_vs0;
      assign w_blank_d = w_blank0;
    end else begin : g_dl
      logic [PIX_LAT-1:0] r_dl_hs, r_dl_vs, r_dl_blank;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_dl_hs    <= '0;
          r_dl_vs    <= '0;
          r_dl_blank <= '0;
        end else if (bus.CE) begin
          r_dl_hs[0]    <= w_hs0;
          r_dl_vs[0]    <= w_vs0;
          r_dl_blank[0] <= w_blank0;
          for (int i = 1; i < int'(PIX_LAT); i++) begin
            r_dl_hs[i]    <= r_dl_hs[i-1];
            r_dl_vs[i]    <= r_dl_vs[i-1];
            r_dl_blank[i] <= r_dl_blank[i-1];
          end
        end
      end
      assign w_hs_d    = r_dl_hs[PIX_LAT-1];
      assign w_vs_d    = r_dl_vs[PIX_LAT-1];
      assign w_blank_d = r_dl_blank[PIX_LAT-1];
    end
  endgenerate

`ifdef VGA_PALETTE_EN
  logic [23:0] r_pal [16];

  function automatic logic [23:0] pal_init(input logic [3:0] idx);
    logic [23:0] v;
    unique case (idx)
      4'd0:    v = 24'h000000;
      4'd1:    v = 24'h800000;
      4'd2:    v = 24'h008000;
      4'd3:    v = 24'h808000;
      4'd4:    v = 24'h000080;
      4'd5:    v = 24'h800080;
      4'd6:    v = 24'h008080;
      4'd7:    v = 24'hc0c0c0;
      4'd8:    v = 24'h808080;
      4'd9:    v = 24'hff0000;
      4'd10:   v = 24'h00ff00;
      4'd11:   v = 24'hffff00;
      4'd12:   v = 24'h0000ff;
      4'd13:   v = 24'hff00ff;
      4'd14:   v = 24'h00ffff;
      default: v = 24'hffffff;
    endcase
    return v;
  endfunction

  // Writes ignore CE; the output stage reads the pre-write value on the write edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) r_pal[i] <= pal_init(4'(i));
    end else if (bus.pal_we) begin
      r_pal[bus.pal_addr] <= bus.pal_data;
    end
  end

  assign w_rgb = r_pal[bus.color[3:0]];
`else
  assign w_rgb = {bus.color[7:5], bus.color[7:5], bus.color[7:6],
                  bus.color[4:2], bus.color[4:2], bus.color[4:3],
                  {4{bus.color[1:0]}}};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
      r_hs    <= ~H_SYNC_POL;
      r_vs    <= ~V_SYNC_POL;
      r_blank <= 1'b0;
    end else if (bus.CE) begin
      {r_r, r_g, r_b} <= w_blank_d ? w_rgb : 24'h000000;
      r_hs            <= w_hs_d ? H_SYNC_POL : ~H_SYNC_POL;
      r_vs            <= w_vs_d ? V_SYNC_POL : ~V_SYNC_POL;
      r_blank         <= w_blank_d;
    end
  end

  assign bus.R        = r_r;
  assign bus.G        = r_g;
  assign bus.B        = r_b;
  assign bus.HS       = r_hs;
  assign bus.VS       = r_vs;
  assign bus.BLANK    = r_blank;
  assign bus.VGA_SYNC = 1'b1;
  assign bus.VGA_CLK  = CLK;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster with random CE and colour.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b0;
  localparam int LAT = 3;
  localparam int CW = 11;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       blank;
  } out_t;

  logic CLK = 1'b0;
  logic RST;
  vga_timing_gen_if #(.COORD_W(CW)) bus ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .PIX_LAT(LAT), .COORD_W(CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  out_t       exp_q[$];
  out_t       mon_x;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         e;
  logic [7:0] c_mem [0:4095];
  logic [23:0] pal_m [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic pal_reset();
    pal_m = '{24'h000000, 24'h800000, 24'h008000, 24'h808000, 24'h000080, 24'h800080,
              24'h008080, 24'hc0c0c0, 24'h808080, 24'hff0000, 24'h00ff00, 24'hffff00,
              24'h0000ff, 24'hff00ff, 24'h00ffff, 24'hffffff};
  endtask

  function automatic logic [23:0] map(input logic [7:0] c);
`ifdef VGA_PALETTE_EN
    return pal_m[c[3:0]];
`else
    logic [2:0] r, g;
    logic [1:0] b;
    r = c[7:5];
    g = c[4:2];
    b = c[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
`endif
  endfunction

  // Output after the CE edge that ends tick ev shows request tick ev-LAT.
  function automatic out_t model(input int ev);
    out_t o;
    int n, h, v;
    logic vis;
    o.r = 8'h00; o.g = 8'h00; o.b = 8'h00;
    o.hs = ~HPOL; o.vs = ~VPOL; o.blank = 1'b0;
    if (ev >= LAT) begin
      n = ev - LAT;
      h = n % HT;
      v = (n / HT) % VT;
      vis = (h < HA) && (v < VA);
      if (vis) {o.r, o.g, o.b} = map(c_mem[n]);
      o.blank = vis;
      o.hs = (h >= HA + HF && h < HA + HF + HSW) ? HPOL : ~HPOL;
      o.vs = (v >= VA + VF && v < VA + VF + VSW) ? VPOL : ~VPOL;
    end
    return o;
  endfunction

  task automatic check_reset(input string tag);
    out_t r0;
    r0.r = 8'h00; r0.g = 8'h00; r0.b = 8'h00;
    r0.hs = ~HPOL; r0.vs = ~VPOL; r0.blank = 1'b0;
    check({tag, "_dac"}, 64'({bus.R, bus.G, bus.B, bus.HS, bus.VS, bus.BLANK}), 64'(r0));
    check({tag, "_pix"}, 64'({bus.pix_x, bus.pix_y, bus.pix_valid, bus.line_start,
                              bus.frame_start}), 64'({CW'(0), CW'(0), 3'b111}));
    check({tag, "_vgasync"}, 64'(bus.VGA_SYNC), 64'(1));
  endtask

  task automatic run(input int ncyc, input int pal_at);
    int h, v;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
`ifdef VGA_PALETTE_EN
      bus.pal_we = 1'b0;
      if (i == pal_at) begin
        bus.pal_we   = 1'b1;
        bus.pal_addr = 4'd3;
        bus.pal_data = 24'h123456;
      end
`endif
      h = e % HT;
      v = (e / HT) % VT;
      check("coords", 64'({bus.pix_x, bus.pix_y, bus.pix_valid, bus.line_start,
                           bus.frame_start}),
            64'({CW'(h), CW'(v), (h < HA) && (v < VA), h == 0, (h == 0) && (v == 0)}));
      bus.CE    = ($urandom_range(0, 9) < 7);
      bus.color = (e >= LAT) ? c_mem[e - LAT] : 8'($urandom);
      if (bus.CE) begin
        exp_q.push_back(model(e));
        e++;
      end
`ifdef VGA_PALETTE_EN
      if (i == pal_at) pal_m[3] = 24'h123456;
`endif
    end
  endtask

  always @(posedge CLK) begin
    if (!RST && bus.CE) begin
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard at %0t: got output with empty queue, required a queued entry",
                 $time);
      end else begin
        mon_x = exp_q.pop_front();
        check("dac", 64'({bus.R, bus.G, bus.B, bus.HS, bus.VS, bus.BLANK}), 64'(mon_x));
      end
    end
  end

  initial begin
    RST = 1'b1;
    bus.CE = 1'b0;
    bus.color = 8'h00;
`ifdef VGA_PALETTE_EN
    bus.pal_we = 1'b0;
    bus.pal_addr = 4'd0;
    bus.pal_data = 24'h0;
`endif
    pal_reset();
    for (int i = 0; i < 4096; i++) c_mem[i] = 8'($urandom);
    for (int i = 0; i < 20; i++) c_mem[i * 7 + 3] = (i % 2) ? 8'hF3 : 8'h03;
    repeat (3) @(negedge CLK);
    check_reset("reset");
    check("vgaclk", 64'(bus.VGA_CLK), 64'(CLK));
    RST = 1'b0;
    e = 0;
    run(1500, 400);

    // Asynchronous reset mid-frame, away from any clock edge.
    @(negedge CLK);
    #2 RST = 1'b1;
    bus.CE = 1'b0;
    #1 check_reset("async_reset");
    exp_q.delete();
    pal_reset();
    for (int i = 0; i < 4096; i++) c_mem[i] = 8'($urandom);
    @(negedge CLK);
    RST = 1'b0;
    e = 0;
    run(1500, 900);

    @(negedge CLK);
    bus.CE = 1'b0;
    repeat (2) @(negedge CLK);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
